// File: rtl/memsrv_pkg.sv
// Shared types and sizes for the main-memory line server.
package memsrv_pkg;

   localparam int unsigned LINE_W         = 128;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned WORDS_PER_LINE = 4;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      READ,
      WRITE,
      RESP
   } state_e;

   typedef enum logic {
      GNT_I,
      GNT_D
   } gnt_e;

endpackage

// File: rtl/memsrv_ram.sv
// Word array: combinational read, clocked write.
// The write port exists only when MEMSRV_WRITE_EN is defined; otherwise the array is read-only.
module memsrv_ram
   import memsrv_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
`ifdef MEMSRV_WRITE_EN
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
`endif
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [2**ADDR_W];

   assign rdata_o = mem_q[raddr_i];

`ifdef MEMSRV_WRITE_EN
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
`endif

endmodule

// File: rtl/mem_line_server.sv
// Main-memory responder for I/D cache misses: arbitration, fixed latency, 4-word line refill.
// Define MEMSRV_WRITE_EN to commit data-side word writes to the array.
module mem_line_server
   import memsrv_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic [LINE_W-1:0] i_line,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic [LINE_W-1:0] d_line,
   output logic              d_ack,
   output logic              busy
);

   localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

   state_e              state_q;
   gnt_e                gnt_q, last_q, gnt_d;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [WORD_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          word_q;
   logic [LINE_W-1:0]   buf_q, line_d;
   logic [LINE_W-1:0]   i_line_q, d_line_q;
   logic                i_ack_q, d_ack_q, busy_q;
   logic [ADDR_W-1:0]   raddr;
   logic [WORD_W-1:0]   rdata;

   // On a tie the side not granted last wins; last_q resets to GNT_I so data wins first.
   always_comb begin
      gnt_d = GNT_I;
      if (i_req && d_req) gnt_d = (last_q == GNT_I) ? GNT_D : GNT_I;
      else if (d_req)     gnt_d = GNT_D;
   end

   assign raddr = {addr_q[ADDR_W-1:2], word_q};

   always_comb begin
      line_d = buf_q;
      line_d[32'(word_q) * WORD_W +: WORD_W] = rdata;
   end

   memsrv_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
`ifdef MEMSRV_WRITE_EN
      .clk_i   (clk),
      .we_i    (state_q == WRITE),
      .waddr_i (addr_q),
      .wdata_i (wdata_q),
`endif
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         gnt_q    <= GNT_I;
         last_q   <= GNT_I;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
         buf_q    <= '0;
         i_line_q <= '0;
         d_line_q <= '0;
         i_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_req || d_req) begin
                  gnt_q   <= gnt_d;
                  last_q  <= gnt_d;
                  we_q    <= (gnt_d == GNT_D) && d_we;
                  addr_q  <= (gnt_d == GNT_D) ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
                  wdata_q <= d_wdata;
                  cnt_q   <= CNT_W'(LATENCY);
                  word_q  <= '0;
                  busy_q  <= 1'b1;
                  if (LATENCY == 0) state_q <= ((gnt_d == GNT_D) && d_we) ? WRITE : READ;
                  else              state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == CNT_W'(1)) state_q <= we_q ? WRITE : READ;
               else                    cnt_q   <= cnt_q - 1'b1;
            end
            READ: begin
               buf_q  <= line_d;
               word_q <= word_q + 1'b1;
               // The last word is merged straight into the output register so ack and line align.
               if (word_q == 2'd3) begin
                  state_q <= RESP;
                  if (gnt_q == GNT_I) begin
                     i_line_q <= line_d;
                     i_ack_q  <= 1'b1;
                  end else begin
                     d_line_q <= line_d;
                     d_ack_q  <= 1'b1;
                  end
               end
            end
            WRITE: begin
               state_q <= RESP;
               d_ack_q <= 1'b1;
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign i_line = i_line_q;
   assign d_line = d_line_q;
   assign i_ack  = i_ack_q;
   assign d_ack  = d_ack_q;
   assign busy   = busy_q;

   logic unused_bits;
   assign unused_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]
`ifndef MEMSRV_WRITE_EN
                          , wdata_q, addr_q[1:0]
`endif
                         };

endmodule

// File: tb/tb_mem_line_server.sv
// Scoreboard bench for mem_line_server: per-side expected queues drained by an ack monitor.
`timescale 1ns/1ps
module tb_mem_line_server;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned LAT    = 4;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         i_req = 1'b0;
   logic [31:0]  i_addr = '0;
   logic [127:0] i_line;
   logic         i_ack;
   logic         d_req = 1'b0;
   logic         d_we = 1'b0;
   logic [31:0]  d_addr = '0;
   logic [31:0]  d_wdata = '0;
   logic [127:0] d_line;
   logic         d_ack;
   logic         busy;

   mem_line_server #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LAT)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_line  (i_line),
      .i_ack   (i_ack),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_line  (d_line),
      .d_ack   (d_ack),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [127:0] line;
      int           cyc;
   } exp_t;

   exp_t         iq[$];
   exp_t         dq[$];
   int           n_vec = 0;
   int           n_bad = 0;
   logic [127:0] d_last = '0;
`ifdef MEMSRV_WRITE_EN
   int           wr_idx = -1;
   logic [31:0]  wr_val = '0;
`endif

   function automatic logic [31:0] pre(input int k);
      if (k < 8) return 32'(32'h1111_1111 * (k + 1));
      return 32'(32'hA000_0000 + k);
   endfunction

   function automatic logic [31:0] word_at(input int k);
`ifdef MEMSRV_WRITE_EN
      if (k == wr_idx) return wr_val;
`endif
      return pre(k);
   endfunction

   function automatic logic [127:0] line_at(input logic [31:0] addr);
      int b;
      b = int'(addr[ADDR_W+1:4]) * 4;
      return {word_at(b + 3), word_at(b + 2), word_at(b + 1), word_at(b)};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rstn && i_ack) begin
         if (iq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL i_ack_unexpected: got ack at cycle %0d, expected none", cyc);
         end else begin
            e = iq.pop_front();
            check("i_ack_cycle", 128'(cyc), 128'(e.cyc));
            check("i_line", i_line, e.line);
         end
      end
      if (rstn && d_ack) begin
         if (dq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL d_ack_unexpected: got ack at cycle %0d, expected none", cyc);
         end else begin
            e = dq.pop_front();
            check("d_ack_cycle", 128'(cyc), 128'(e.cyc));
            check("d_line", d_line, e.line);
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_i();
      int t = 0;
      do begin @(negedge clk); t++; end while (!i_ack && t < 200);
      if (!i_ack) begin
         n_vec++; n_bad++;
         $display("FAIL i_ack_timeout: got no ack, expected one within 200 cycles");
      end
      sync();
      i_req = 1'b0;
   endtask

   task automatic wait_d();
      int t = 0;
      do begin @(negedge clk); t++; end while (!d_ack && t < 200);
      if (!d_ack) begin
         n_vec++; n_bad++;
         $display("FAIL d_ack_timeout: got no ack, expected one within 200 cycles");
      end
      sync();
      d_req = 1'b0;
   endtask

   // Called at posedge+1: the current cycle is cycle 0 of the request.
   task automatic req_i(input logic [31:0] addr, input int off);
      exp_t e;
      e.line = line_at(addr);
      e.cyc  = cyc + off;
      iq.push_back(e);
      i_addr = addr;
      i_req  = 1'b1;
      wait_i();
   endtask

   task automatic req_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int off);
      exp_t e;
      if (we) begin
         e.line = d_last;
`ifdef MEMSRV_WRITE_EN
         wr_idx = int'(addr[ADDR_W+1:2]);
         wr_val = wdata;
`endif
      end else begin
         e.line = line_at(addr);
         d_last = e.line;
      end
      e.cyc = cyc + off;
      dq.push_back(e);
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      d_req   = 1'b1;
      wait_d();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) sync();
      rstn = 1'b1;
      d_last = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench exceeded its time limit");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int k = 0; k < 16; k++) dut.u_ram.mem_q[k] = pre(k);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_i_ack", i_ack, 1'b0);
      check("rst_d_ack", d_ack, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_i_line", i_line, '0);
      check("rst_d_line", d_line, '0);
      sync();
      rstn = 1'b1;

      // Refill of line 0 with busy profile over cycles 0..10
      fork
         req_i(32'h0000_0008, LAT + 5);
         for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            check("busy_profile", busy, (k >= 1 && k <= 9));
         end
      join
      sync();

      // Word write then refill of the same line
      req_d(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, LAT + 2);
      req_d(1'b0, 32'h0000_0010, 32'h0, LAT + 5);

      // Tie after reset: data wins first
      do_reset();
      fork
         req_i(32'h0000_0020, 2 * (LAT + 5) + 1);
         req_d(1'b0, 32'h0000_0030, 32'h0, LAT + 5);
      join

      // Sustained contention: grants alternate D, I, D, I
      fork
         begin
            req_d(1'b0, 32'h0000_0000, 32'h0, LAT + 5);
            req_d(1'b0, 32'h0000_0010, 32'h0, 2 * (LAT + 5) + 1);
         end
         begin
            req_i(32'h0000_0010, 2 * (LAT + 5) + 1);
            req_i(32'h0000_0030, 2 * (LAT + 5) + 1);
         end
      join

      // Reset in cycle 7 (READ) aborts the refill; the held request is served afterwards
      i_addr = 32'h0000_0008;
      i_req  = 1'b1;
      repeat (7) sync();
      rstn = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_i_ack", i_ack, 1'b0);
      check("abort_i_line", i_line, '0);
      check("abort_d_line", d_line, '0);
      sync();
      rstn = 1'b1;
      d_last = '0;
      begin
         exp_t e;
         e.line = line_at(32'h0000_0008);
         e.cyc  = cyc + LAT + 5;
         iq.push_back(e);
      end
      wait_i();

      repeat (12) sync();
      check("iq_drained", 128'(iq.size()), '0);
      check("dq_drained", 128'(dq.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_line_server.md
# mem_line_server

Main-memory responder for the pipelined MIPS core: the far end of the instruction-cache and data-cache miss interfaces. It accepts line-refill requests from both caches and word writes from the data side, arbitrates between them, and models a fixed access latency. For refills it assembles a 128-bit line from four 32-bit word reads and returns it with a one-cycle acknowledge. One request is in service at a time.

## Interface

Parameters:
- ADDR_W, 10, word-address width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 4, wait cycles before array access; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction refill request; level, held until i_ack.
- i_addr  in  32  instruction miss byte address; bits [3:0] ignored.
- i_line  out  128  refilled line; valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse, instruction side.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = word write, 0 = line refill; sampled with d_req.
- d_addr  in  32  data byte address; refill ignores [3:0], write ignores [1:0].
- d_wdata  in  32  write data.
- d_line  out  128  refilled line; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse, data side.
- busy  out  1  high whenever state is not IDLE.

## Operation

- FSM states: IDLE, WAIT, READ, WRITE, RESP.
- IDLE: if any request is present, grant one, latch address, write flag, and write data; go to WAIT, or directly to READ/WRITE when LATENCY=0.
- Arbitration: a single request wins. When both requests are present, the side not granted last wins. The last-grant bit resets to "instruction", so the first tie goes to data.
- WAIT: down-counter loaded with LATENCY; exits to READ (refill) or WRITE (write) when the count reaches 1.
- READ: four cycles. Cycle k reads the word at line address {addr[ADDR_W+1:4], k[1:0]} into line buffer bits [32k+31:32k]; word 0 lands in the LSBs. Then RESP.
- WRITE: one cycle; stores wdata at addr[ADDR_W+1:2]. Then RESP.
- RESP: the granted side's ack is 1 and its line output drives the line buffer. Then IDLE.
- Line outputs hold their last value when not acked. d_line is not updated by writes.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo memory size.
- The requester drops req on the clock edge at which it sees ack. IDLE in the following cycle therefore never re-serves a completed request.
- Reset: state IDLE; i_ack, d_ack, and busy are 0; i_line and d_line are 0; counter and last-grant are cleared. Memory contents are not reset.
- Reset mid-operation aborts the request with no ack. A write is committed only if the WRITE edge occurred before rstn fell.

## Timing

- Count cycle 0 as the IDLE cycle in which a request is sampled.
- Refill: ack is high in cycle LATENCY+5 (5 with LATENCY=0, 9 with default).
- Write: ack is high in cycle LATENCY+2.
- Minimum spacing between consecutive grants is one IDLE cycle after RESP.
- A losing request waits in full for the winner's service.
- Array read is combinational and array write is synchronous; outputs are registered.

## Configuration

- MEMSRV_WRITE_EN defined: writes are stored as described above.
- MEMSRV_WRITE_EN undefined:
  - The array is read-only; contents come only from simulation preload.
  - Write requests still pass WAIT and WRITE and receive d_ack at LATENCY+2, so the core never hangs, but memory is unchanged.

## Structure

- Package memsrv_pkg holds:
  - LINE_W=128, WORD_W=32, WORDS_PER_LINE=4;
  - the FSM state enum;
  - the grant-side enum (GNT_I, GNT_D).
- One sub-module, memsrv_ram: word array with combinational read and clocked write enable. The write port is present only under MEMSRV_WRITE_EN. Arbiter, counter, and FSM stay in mem_line_server.

## Test plan

- Refill: preload words 0..3 = 0x11111111..0x44444444; i_req with i_addr=0x00000008, LATENCY=4 -> i_ack only in cycle 9, i_line=0x44444444_33333333_22222222_11111111, busy high in cycles 1..9.
- Write then read: d_we=1, d_addr=0x14, d_wdata=0xDEADBEEF -> d_ack in cycle 6. Then refill at d_addr=0x10 -> d_line[63:32]=0xDEADBEEF.
- Tie after reset: i_req and d_req rise together -> d_ack first in cycle 9, i_ack in cycle 19.
- Repeated contention: keep both sides requesting for four requests -> grants alternate D, I, D, I.
- Reset during READ: assert rstn=0 in cycle 7 -> no ack, busy=0, lines=0. After release, the same i_req is served with ack at LATENCY+5.
- MEMSRV_WRITE_EN undefined: write 0xDEADBEEF to 0x14 -> d_ack in cycle 6. Refill of 0x10 -> d_line[63:32] keeps the preloaded value.
